// File: rtl/mc_controlunit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory datapath, with memory handshake and sticky illegal trap.
module mc_controlunit #(
   parameter int DATA_WIDTH = 32,
   parameter int ALUCTRL_W  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DATA_WIDTH-1:0] Instr_i,
   input  logic                 MemReady_i,
   input  logic                 Zero_i,
   input  logic                 Lt_i,
   input  logic                 Ltu_i,
   output logic                 PCWrite_o,
   output logic                 AdrSrc_o,
   output logic                 MemRead_o,
   output logic                 MemWrite_o,
   output logic                 IRWrite_o,
   output logic                 RegWrite_o,
   output logic [1:0]           ResultSrc_o,
   output logic [1:0]           ALUSrcA_o,
   output logic [1:0]           ALUSrcB_o,
   output logic [2:0]           ImmSrc_o,
   output logic [ALUCTRL_W-1:0] ALUCtrl_o,
   output logic                 Illegal_o,
   output logic [3:0]           State_o
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
      S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
      S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
      S_JALR_LINK = 4'd12, S_LUI = 4'd13, S_TRAP = 4'd14
   } state_t;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0), ALU_SUB = ALUCTRL_W'(1),
      ALU_AND = ALUCTRL_W'(2), ALU_OR = ALUCTRL_W'(3), ALU_XOR = ALUCTRL_W'(4),
      ALU_SLT = ALUCTRL_W'(5), ALU_SLTU = ALUCTRL_W'(6), ALU_SRL = ALUCTRL_W'(7),
      ALU_SLL = ALUCTRL_W'(8), ALU_SRA = ALUCTRL_W'(9);

   localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

   state_t     state, nxt;
   logic       illegal;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7_5;
   logic       taken, br_bad;
   logic       pcw, mr, mw, irw, rw;
   logic       unused_instr;

   assign op   = Instr_i[6:0];
   assign f3   = Instr_i[14:12];
   assign f7_5 = Instr_i[30];
   assign unused_instr = ^Instr_i;

   // funct7_5 selects SUB only for register-register ops; shifts always honour it
   function automatic logic [ALUCTRL_W-1:0] alu_dec(input logic [2:0] fn, input logic alt,
                                                    input logic is_r);
      case (fn)
         3'b000:  alu_dec = (alt && is_r) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_dec = ALU_SLL;
         3'b010:  alu_dec = ALU_SLT;
         3'b011:  alu_dec = ALU_SLTU;
         3'b100:  alu_dec = ALU_XOR;
         3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_dec = ALU_OR;
         default: alu_dec = ALU_AND;
      endcase
   endfunction

   always_comb begin
      taken  = 1'b0;
      br_bad = 1'b0;
      case (f3)
         3'b000:  taken = Zero_i;
         3'b001:  taken = !Zero_i;
         3'b100:  taken = Lt_i;
         3'b101:  taken = !Lt_i;
         3'b110:  taken = Ltu_i;
         3'b111:  taken = !Ltu_i;
         default: br_bad = 1'b1;
      endcase
   end

   always_comb begin
      nxt         = state;
      pcw         = 1'b0;
      mr          = 1'b0;
      mw          = 1'b0;
      irw         = 1'b0;
      rw          = 1'b0;
      AdrSrc_o    = 1'b0;
      ResultSrc_o = 2'b00;
      ALUSrcA_o   = 2'b00;
      ALUSrcB_o   = 2'b00;
      ImmSrc_o    = IMM_I;
      ALUCtrl_o   = ALU_ADD;
      case (state)
         S_FETCH: begin
            mr = 1'b1; ALUSrcB_o = 2'b10; ResultSrc_o = 2'b10;
            pcw = MemReady_i; irw = MemReady_i;
            if (MemReady_i) nxt = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA_o = 2'b01; ALUSrcB_o = 2'b01;
            case (op)
               7'd35:        ImmSrc_o = IMM_S;
               7'd99:        ImmSrc_o = IMM_B;
               7'd111:       ImmSrc_o = IMM_J;
               7'd55, 7'd23: ImmSrc_o = IMM_U;
               default:      ImmSrc_o = IMM_I;
            endcase
            case (op)
               7'd3, 7'd35:  nxt = S_MEMADR;
               7'd51:        nxt = S_EXEC_R;
               7'd19:        nxt = S_EXEC_I;
               7'd99:        nxt = S_BRANCH;
               7'd111:       nxt = S_JAL;
               7'd103:       nxt = (f3 == 3'b000) ? S_JALR : S_TRAP;
               7'd55, 7'd23: nxt = S_LUI;
               default:      nxt = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA_o = 2'b10; ALUSrcB_o = 2'b01;
            ImmSrc_o  = (op == 7'd35) ? IMM_S : IMM_I;
            nxt       = (op == 7'd35) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc_o = 1'b1; mr = 1'b1;
            if (MemReady_i) nxt = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc_o = 2'b01; rw = 1'b1; nxt = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc_o = 1'b1; mw = 1'b1;
            if (MemReady_i) nxt = S_FETCH;
         end
         S_EXEC_R: begin
            ALUSrcA_o = 2'b10; ALUCtrl_o = alu_dec(f3, f7_5, 1'b1); nxt = S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA_o = 2'b10; ALUSrcB_o = 2'b01;
            ALUCtrl_o = alu_dec(f3, f7_5, 1'b0); nxt = S_ALUWB;
         end
         S_ALUWB: begin
            rw = 1'b1; nxt = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA_o = 2'b10; ALUCtrl_o = ALU_SUB;
            pcw = taken;
            nxt = br_bad ? S_TRAP : S_FETCH;
         end
         S_JAL: begin
            ALUSrcA_o = 2'b01; ALUSrcB_o = 2'b10; pcw = 1'b1; nxt = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA_o = 2'b10; ALUSrcB_o = 2'b01; ResultSrc_o = 2'b10;
            pcw = 1'b1; nxt = S_JALR_LINK;
         end
         S_JALR_LINK: begin
            ALUSrcA_o = 2'b01; ALUSrcB_o = 2'b10; ResultSrc_o = 2'b10;
            rw = 1'b1; nxt = S_FETCH;
         end
         S_LUI: begin
            // AUIPC reuses this state, adding the immediate to OldPC instead of zero
            ALUSrcA_o = (op == 7'd23) ? 2'b01 : 2'b11;
            ALUSrcB_o = 2'b01; ImmSrc_o = IMM_U; nxt = S_ALUWB;
         end
         default: nxt = S_TRAP;
      endcase
   end

   // Strobes are masked by reset so nothing is written while the FSM is held
   assign PCWrite_o  = pcw & rst_ni;
   assign MemRead_o  = mr  & rst_ni;
   assign MemWrite_o = mw  & rst_ni;
   assign IRWrite_o  = irw & rst_ni;
   assign RegWrite_o = rw  & rst_ni;
   assign Illegal_o  = illegal;
   assign State_o    = state;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt == S_TRAP) illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mc_controlunit.sv
// Scoreboard bench for mc_controlunit: per-cycle expected state/control words are
// queued with their stimulus and compared one cycle at a time.
module tb_mc_controlunit;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic [31:0] Instr_i = '0;
   logic        MemReady_i = 1'b0, Zero_i = 1'b0, Lt_i = 1'b0, Ltu_i = 1'b0;
   logic        PCWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o, Illegal_o;
   logic [1:0]  ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
   logic [2:0]  ImmSrc_o;
   logic [3:0]  ALUCtrl_o, State_o;

   mc_controlunit #(.DATA_WIDTH(32), .ALUCTRL_W(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .Instr_i(Instr_i), .MemReady_i(MemReady_i),
      .Zero_i(Zero_i), .Lt_i(Lt_i), .Ltu_i(Ltu_i), .PCWrite_o(PCWrite_o),
      .AdrSrc_o(AdrSrc_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .ResultSrc_o(ResultSrc_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ImmSrc_o(ImmSrc_o),
      .ALUCtrl_o(ALUCtrl_o), .Illegal_o(Illegal_o), .State_o(State_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic        rdy, z, lt, ltu;
      logic [3:0]  st;
      logic [18:0] ctrl;
      logic        ill;
   } ent_t;

   ent_t        sb[$];
   int          n_tot = 0, n_bad = 0, n_cyc = 0;
   logic [31:0] cur_instr = '0;
   logic        cur_rdy = 1'b1, cur_z = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0, cur_ill = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] ctrl_now();
      return {PCWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o,
              ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUCtrl_o};
   endfunction

   task automatic ex(input logic [3:0] st, input logic pcw, adr, mr, mw, ir, rw,
                     input logic [1:0] rs, a, b, input logic [2:0] imm, input logic [3:0] alu);
      ent_t e;
      e.instr = cur_instr; e.rdy = cur_rdy; e.z = cur_z; e.lt = cur_lt; e.ltu = cur_ltu;
      e.st = st; e.ctrl = {pcw, adr, mr, mw, ir, rw, rs, a, b, imm, alu}; e.ill = cur_ill;
      sb.push_back(e);
   endtask

   task automatic fetch(input logic r);
      cur_rdy = r;
      ex(4'd0, r, 0, 1, 0, r, 0, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0);
   endtask
   task automatic dec(input logic [2:0] imm);
      ex(4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 4'd0);
   endtask
   task automatic aluwb();
      ex(4'd8, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
   endtask
   task automatic r_op(input logic [31:0] ins, input logic [3:0] alu);
      cur_instr = ins; fetch(1); dec(3'd0);
      ex(4'd6, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, alu); aluwb();
   endtask
   task automatic i_op(input logic [31:0] ins, input logic [3:0] alu);
      cur_instr = ins; fetch(1); dec(3'd0);
      ex(4'd7, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, alu); aluwb();
   endtask
   task automatic br(input logic [31:0] ins, input logic z, lt, ltu, tk);
      cur_instr = ins; cur_z = z; cur_lt = lt; cur_ltu = ltu;
      fetch(1); dec(3'd2);
      ex(4'd9, tk, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1);
   endtask

   task automatic run_q();
      ent_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk_i);
         Instr_i = e.instr; MemReady_i = e.rdy; Zero_i = e.z; Lt_i = e.lt; Ltu_i = e.ltu;
         #1;
         chk($sformatf("state@%0d", n_cyc), State_o, e.st);
         chk($sformatf("ctrl@%0d", n_cyc), ctrl_now(), e.ctrl);
         chk($sformatf("ill@%0d", n_cyc), Illegal_o, e.ill);
         n_cyc++;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, State_o, 4'd0);
      chk({tag, "_strobes"}, {PCWrite_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o}, 5'b0);
      chk({tag, "_ill"}, Illegal_o, 1'b0);
   endtask

   initial begin
      MemReady_i = 1'b1;
      #2 chk_reset("por");
      MemReady_i = 1'b0;
      @(negedge clk_i) rst_ni = 1'b1;

      // add with a one-cycle fetch stall, then other R/I ALU mappings
      cur_instr = 32'h002081B3; fetch(0);
      r_op(32'h002081B3, 4'd0);
      r_op(32'h402081B3, 4'd1);
      r_op(32'h0020B1B3, 4'd6);
      i_op(32'h40008093, 4'd0);
      i_op(32'h4010D093, 4'd9);
      // lw with three wait cycles in MEMREAD
      cur_instr = 32'h0000A183; fetch(1); dec(3'd0);
      ex(4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0);
      cur_rdy = 0;
      repeat (3) ex(4'd3, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      cur_rdy = 1;
      ex(4'd3, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      ex(4'd4, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0);
      // sw with one wait cycle
      cur_instr = 32'h0020A023; fetch(1); dec(3'd1);
      ex(4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 4'd0);
      cur_rdy = 0; ex(4'd5, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      cur_rdy = 1; ex(4'd5, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      // branches
      br(32'h00209063, 0, 0, 0, 1);
      br(32'h00209063, 1, 0, 0, 0);
      br(32'h0020E063, 0, 0, 1, 1);
      br(32'h0020D063, 0, 1, 0, 0);
      br(32'h00208063, 1, 0, 0, 1);
      cur_z = 0; cur_lt = 0; cur_ltu = 0;
      // jal, jalr, lui, auipc
      cur_instr = 32'h000000EF; fetch(1); dec(3'd4);
      ex(4'd10, 1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0); aluwb();
      cur_instr = 32'h000080E7; fetch(1); dec(3'd0);
      ex(4'd11, 1, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd1, 3'd0, 4'd0);
      ex(4'd12, 0, 0, 0, 0, 0, 1, 2'd2, 2'd1, 2'd2, 3'd0, 4'd0);
      cur_instr = 32'h000010B7; fetch(1); dec(3'd3);
      ex(4'd13, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd3, 4'd0); aluwb();
      cur_instr = 32'h00001097; fetch(1); dec(3'd3);
      ex(4'd13, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd3, 4'd0); aluwb();
      // lw parked in MEMREAD, then reset mid-cycle
      cur_instr = 32'h0000A183; fetch(1); dec(3'd0);
      ex(4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0);
      cur_rdy = 0;
      repeat (2) ex(4'd3, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      run_q();

      #2 rst_ni = 1'b0; MemReady_i = 1'b1;
      #1 chk_reset("rst_mid");
      @(negedge clk_i) #1 chk_reset("rst_hold");
      MemReady_i = 1'b0; rst_ni = 1'b1;

      // reserved branch funct3 traps
      cur_rdy = 1;
      cur_instr = 32'h0020A063; fetch(1); dec(3'd2);
      ex(4'd9, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1);
      cur_ill = 1;
      repeat (3) ex(4'd14, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      run_q();
      MemReady_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1 chk_reset("rst_trap");
      @(negedge clk_i);
      MemReady_i = 1'b0; rst_ni = 1'b1;

      // unknown opcode: trap held for 10 cycles
      cur_ill = 0; cur_instr = 32'h0000007F; fetch(1); dec(3'd0);
      cur_ill = 1;
      repeat (10) ex(4'd14, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      run_q();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
